robot_motion_ctrl: RTL

Downstream motion executor for the wall-following robot. It consumes the `front`/`rotate` command pair produced by the robot decision FSM and converts each command into a timed motor sequence: wheel enables, wheel directions and step pulses. A `ready` output throttles the decision FSM so it only advances once per completed move.

---
 rtl/robot_motion_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/robot_motion_ctrl.sv
// Motion executor: turns front/rotate commands into timed wheel enable/direction/step sequences.
// Optional MOTION_HEADING_EN adds a 2-bit compass heading that advances on each clockwise rotation.
module robot_motion_ctrl #(
  parameter int unsigned STEP_DIV   = 4,
  parameter int unsigned FWD_STEPS  = 8,
  parameter int unsigned ROT_STEPS  = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       front,
  input  logic       rotate,
  output logic       ready,
  output logic       done,
  output logic       motor_l_en,
  output logic       motor_r_en,
  output logic       motor_l_dir,
  output logic       motor_r_dir,
  output logic       step
`ifdef MOTION_HEADING_EN
  ,
  output logic [1:0] heading
`endif
);

  localparam int unsigned MAX_STEPS = (FWD_STEPS > ROT_STEPS) ? FWD_STEPS : ROT_STEPS;
  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam int unsigned TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(STEP_DIV - 1);
  localparam logic [SW-1:0] FWD_LAST    = SW'(FWD_STEPS - 1);
  localparam logic [SW-1:0] ROT_LAST    = SW'(ROT_STEPS - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, FWD, ROT, SETTLE} state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [SW-1:0] steps_q;
  logic [TW-1:0] settle_q;
  logic          ready_q;
  logic          done_q;
  logic          en_q;
  logic          r_dir_q;
  logic          moving;
  logic          last_step;
`ifdef MOTION_HEADING_EN
  logic [1:0]    heading_q;
`endif

  // Step strobe decodes straight from registered state so it lines up with the prescaler wrap.
  assign moving    = (state_q == FWD) || (state_q == ROT);
  assign step      = moving && (presc_q == PRESC_LAST);
  assign last_step = (steps_q == ((state_q == ROT) ? ROT_LAST : FWD_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      steps_q   <= '0;
      settle_q  <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      r_dir_q   <= 1'b0;
`ifdef MOTION_HEADING_EN
      heading_q <= 2'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          presc_q  <= '0;
          steps_q  <= '0;
          settle_q <= '0;
          // Rotate has priority when both commands are raised together.
          if (rotate) begin
            state_q <= ROT;
            ready_q <= 1'b0;
            en_q    <= 1'b1;
            r_dir_q <= 1'b0;
          end else if (front) begin
            state_q <= FWD;
            ready_q <= 1'b0;
            en_q    <= 1'b1;
            r_dir_q <= 1'b1;
          end
        end
        FWD, ROT: begin
          if (step) begin
            presc_q <= '0;
            if (last_step) begin
              state_q <= SETTLE;
              steps_q <= '0;
              en_q    <= 1'b0;
              r_dir_q <= 1'b0;
`ifdef MOTION_HEADING_EN
              if (state_q == ROT) heading_q <= heading_q + 2'd1;
`endif
            end else begin
              steps_q <= steps_q + SW'(1);
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q  <= IDLE;
            settle_q <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            settle_q <= settle_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign motor_l_en  = en_q;
  assign motor_r_en  = en_q;
  assign motor_l_dir = en_q;
  assign motor_r_dir = r_dir_q;
`ifdef MOTION_HEADING_EN
  assign heading     = heading_q;
`endif

endmodule
